// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b type definitions.
//   lc3b_word       16-bit datapath word
//   lc3b_mem_wmask  2-bit byte write mask (bit 0 = low byte, bit 1 = high byte)
//   lc3b_mem_state  memory responder FSM states
//   lc3b_mem_op     latched memory operation
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lc3b_mem_state;

  typedef enum logic {
    mem_op_read  = 1'b0,
    mem_op_write = 1'b1
  } lc3b_mem_op;

  // Width of the latency down-counter; covers LATENCY up to 255.
  localparam int LC3B_MEM_CNT_W = 8;

endpackage

// File: rtl/lc3b_mem_array.sv
// lc3b_mem_array: 2^ADDR_W x 16 word store, single synchronous port.
//   clk_i    clock
//   addr_i   word index
//   wdata_i  write data
//   be_i     per-byte write enable (bit 0 low byte, bit 1 high byte)
//   we_i     write strobe
//   re_i     read strobe; rdata_o updates on the edge re_i is sampled high
//   rdata_o  registered read data, held until the next read
// No reset: contents and read register are left as-is by rst.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  lc3b_word          wdata_i,
  input  lc3b_mem_wmask     be_i,
  input  logic              we_i,
  input  logic              re_i,
  output lc3b_word          rdata_o
);

  lc3b_word mem_q [2**ADDR_W];
  lc3b_word rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: memory-side responder for the LC-3b memory port.
// Accepts a held mem_read/mem_write request, waits LATENCY cycles, then
// pulses mem_resp for one cycle. The store access happens on the edge that
// enters RESP, so mem_rdata is valid during the mem_resp cycle.
//   clk, rst           clock, asynchronous active-high reset
//   mem_read/write     requests, held by the CPU until mem_resp
//   mem_address        byte address; word index is mem_address[ADDR_W:1]
//   mem_wdata          write data
//   mem_byte_enable    byte write mask
//   mem_rdata          read data, held until the next read completes
//   mem_resp           one-cycle completion pulse
//   mem_err            sticky: a request arrived with read and write both high
//   rd_count/wr_count  completed-transaction counters (saturating)
// Handshake: a request is accepted when the FSM is in IDLE and mem_read or
// mem_write is high; it completes in the single cycle mem_resp is high.
// Optional feature macro: LC3B_MEM_STATS_EN enables rd_count/wr_count;
// without it both are tied to 0.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          mem_err,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);

  localparam int CNT_W = LC3B_MEM_CNT_W;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  lc3b_mem_state     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  lc3b_mem_op        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  lc3b_word          wdata_q, wdata_d;
  lc3b_mem_wmask     be_q, be_d;
  logic              err_q, err_d;
  // Masks the array's unreset read register until a read has completed.
  logic              rvalid_q, rvalid_d;

  logic              req;
  lc3b_mem_op        req_op;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_addr;
  lc3b_word          arr_wdata;
  lc3b_mem_wmask     arr_be;
  lc3b_word          arr_rdata;

  // Only mem_address[ADDR_W:1] selects a word; the rest are don't-care.
  logic unused_addr;
  assign unused_addr = ^mem_address;

  assign req    = mem_read | mem_write;
  assign req_op = mem_write ? mem_op_write : mem_op_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= mem_op_read;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    err_d     = err_q;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = addr_q;
    arr_wdata = wdata_q;
    arr_be    = be_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = req_op;
          addr_d  = mem_address[ADDR_W:1];
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          if (mem_read && mem_write) err_d = 1'b1;
          if (LATENCY == 1) begin
            // Going straight to RESP: the latches are not loaded yet, so the
            // array access uses the live request.
            state_d   = RESP;
            arr_addr  = mem_address[ADDR_W:1];
            arr_wdata = mem_wdata;
            arr_be    = mem_byte_enable;
            arr_we    = (req_op == mem_op_write);
            arr_re    = (req_op == mem_op_read);
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          arr_we  = (op_q == mem_op_write);
          arr_re  = (op_q == mem_op_read);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rvalid_d = rvalid_q | arr_re;
  end

  // Gating with rst keeps an edge coinciding with reset from touching the store.
  lc3b_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .we_i    (arr_we & ~rst),
    .re_i    (arr_re & ~rst),
    .rdata_o (arr_rdata)
  );

  assign mem_resp  = (state_q == RESP);
  assign mem_err   = err_q;
  assign mem_rdata = rvalid_q ? arr_rdata : '0;

`ifdef LC3B_MEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == RESP) begin
      if (op_q == mem_op_read && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      if (op_q == mem_op_write && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb_lc3b_mem_responder: directed bench for lc3b_mem_responder.
// Instance A: LATENCY=4, ADDR_W=10. Instance B: LATENCY=1, ADDR_W=10.
// Read expectations come from a bench-side word model and are queued when
// the read is issued, then popped when mem_resp is seen.
module tb_lc3b_mem_responder;

`ifdef LC3B_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;

  // instance A
  logic        a_read, a_write;
  logic [15:0] a_addr, a_wdata;
  logic [1:0]  a_be;
  logic [15:0] a_rdata;
  logic        a_resp, a_err;
  logic [15:0] a_rd_count, a_wr_count;

  // instance B
  logic        b_read, b_write;
  logic [15:0] b_addr, b_wdata;
  logic [1:0]  b_be;
  logic [15:0] b_rdata;
  logic        b_resp, b_err;
  logic [15:0] b_rd_count, b_wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model [1024];
  logic [15:0] exp_q [$];
  int          rd_exp = 0;
  int          wr_exp = 0;

  lc3b_mem_responder #(.LATENCY(4), .ADDR_W(10)) dut_a (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (a_read),
    .mem_write       (a_write),
    .mem_address     (a_addr),
    .mem_wdata       (a_wdata),
    .mem_byte_enable (a_be),
    .mem_rdata       (a_rdata),
    .mem_resp        (a_resp),
    .mem_err         (a_err),
    .rd_count        (a_rd_count),
    .wr_count        (a_wr_count)
  );

  lc3b_mem_responder #(.LATENCY(1), .ADDR_W(10)) dut_b (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (b_read),
    .mem_write       (b_write),
    .mem_address     (b_addr),
    .mem_wdata       (b_wdata),
    .mem_byte_enable (b_be),
    .mem_rdata       (b_rdata),
    .mem_resp        (b_resp),
    .mem_err         (b_err),
    .rd_count        (b_rd_count),
    .wr_count        (b_wr_count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_a_counts(input string tag);
    check({tag, "_rd_count"}, a_rd_count, STATS ? 16'(rd_exp) : 16'd0);
    check({tag, "_wr_count"}, a_wr_count, STATS ? 16'(wr_exp) : 16'd0);
  endtask

  // One complete transaction on instance A, with latency and data checks.
  task automatic a_xact(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, input logic [1:0] be, input string tag);
    int          k;
    bit          got;
    logic [15:0] e;
    logic [9:0]  idx;
    idx = addr[10:1];
    @(posedge clk);
    #1;
    a_read  = rd;
    a_write = wr;
    a_addr  = addr;
    a_wdata = data;
    a_be    = be;
    if (wr) begin
      if (be[0]) model[idx][7:0]  = data[7:0];
      if (be[1]) model[idx][15:8] = data[15:8];
      wr_exp++;
    end else begin
      exp_q.push_back(model[idx]);
      rd_exp++;
    end
    k   = 0;
    got = 1'b0;
    while (k <= 20 && !got) begin
      @(negedge clk);
      if (a_resp) got = 1'b1;
      else k++;
    end
    check({tag, "_latency"}, got ? 16'(k) : 16'hFFFF, 16'd4);
    if (!wr) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, a_rdata, e);
    end
    a_read  = 1'b0;
    a_write = 1'b0;
    @(negedge clk);
    check({tag, "_resp_pulse"}, {15'd0, a_resp}, 16'd0);
  endtask

  initial begin
    int          seen;
    logic [15:0] hold;
    logic [15:0] prior;
    rst = 1'b1;
    a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_resp",  {15'd0, a_resp}, 16'd0);
    check("reset_rdata", a_rdata, 16'd0);
    check("reset_err",   {15'd0, a_err}, 16'd0);
    check("reset_rd_count", a_rd_count, 16'd0);
    check("reset_wr_count", a_wr_count, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // basic write then read
    a_xact(0, 1, 16'h0040, 16'hBEEF, 2'b11, "wr_beef");
    a_xact(1, 0, 16'h0040, 16'h0000, 2'b00, "rd_beef");

    // byte-masked write, odd byte address
    a_xact(0, 1, 16'h0010, 16'h1234, 2'b11, "wr_1234");
    hold = a_rdata;
    a_xact(0, 1, 16'h0010, 16'hAB00, 2'b10, "wr_ab00_hi");
    check("rdata_hold_after_write", a_rdata, hold);
    a_xact(1, 0, 16'h0011, 16'h0000, 2'b00, "rd_ab34");

    // address wrap
    a_xact(0, 1, 16'h0802, 16'h5555, 2'b11, "wr_wrap");
    a_xact(1, 0, 16'h0002, 16'h0000, 2'b00, "rd_wrap");

    // empty byte enable still completes, store unchanged
    a_xact(0, 1, 16'h0040, 16'h0000, 2'b00, "wr_be00");
    a_xact(1, 0, 16'h0040, 16'h0000, 2'b00, "rd_after_be00");
    check_a_counts("after_basic");

    // abort in WAIT
    a_xact(0, 1, 16'h0020, 16'h2020, 2'b11, "wr_prior");
    prior = model[16'h0020 >> 1];
    @(posedge clk);
    #1;
    a_write = 1'b1; a_addr = 16'h0020; a_wdata = 16'h9999; a_be = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #1 a_write = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_resp) seen++;
    end
    check("abort_no_resp", 16'(seen), 16'd0);
    check_a_counts("after_abort");
    check("abort_model_unchanged", model[16'h0020 >> 1], prior);
    a_xact(1, 0, 16'h0020, 16'h0000, 2'b00, "rd_after_abort");

    // read and write together: write wins, error sticks
    a_xact(1, 1, 16'h0030, 16'h7777, 2'b11, "rw_both");
    check("err_set", {15'd0, a_err}, 16'd1);
    a_xact(1, 0, 16'h0030, 16'h0000, 2'b00, "rd_after_both");
    check("err_sticky", {15'd0, a_err}, 16'd1);
    check_a_counts("before_reset");

    // reset in the middle of a pending write
    @(posedge clk);
    #1;
    a_write = 1'b1; a_addr = 16'h0040; a_wdata = 16'h0000; a_be = 2'b11;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_resp",  {15'd0, a_resp}, 16'd0);
    check("midrst_rdata", a_rdata, 16'd0);
    check("midrst_err",   {15'd0, a_err}, 16'd0);
    check("midrst_rd_count", a_rd_count, 16'd0);
    check("midrst_wr_count", a_wr_count, 16'd0);
    a_write = 1'b0;
    rd_exp = 0;
    wr_exp = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    a_xact(1, 0, 16'h0040, 16'h0000, 2'b00, "rd_after_rst");
    check_a_counts("after_reset");

    // instance B: LATENCY=1, back-to-back reads
    @(posedge clk);
    #1;
    b_write = 1'b1; b_addr = 16'h0006; b_wdata = 16'h00C3; b_be = 2'b11;
    @(negedge clk);
    check("b_wr_c0_resp", {15'd0, b_resp}, 16'd0);
    @(negedge clk);
    check("b_wr_c1_resp", {15'd0, b_resp}, 16'd1);
    b_write = 1'b0;
    @(posedge clk);
    #1;
    b_read = 1'b1; b_addr = 16'h0006;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("b_rd_c%0d_resp", c), {15'd0, b_resp},
            (c % 2 == 1 && c <= 5) ? 16'd1 : 16'd0);
      if (c % 2 == 1 && c <= 5) check($sformatf("b_rd_c%0d_rdata", c), b_rdata, 16'h00C3);
      if (c == 5) b_read = 1'b0;
    end
    check("b_rd_count", b_rd_count, STATS ? 16'd3 : 16'd0);
    check("b_wr_count", b_wr_count, STATS ? 16'd1 : 16'd0);
    check("b_err", {15'd0, b_err}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_responder.md
# lc3b_mem_responder

Memory-side responder for the LC-3b datapath's memory port. It accepts word-wide read and write requests from the CPU control unit, holds each request for a parameterised latency, then completes it with a single-cycle `mem_resp` pulse. It contains a byte-maskable word store. It sits at the far end of the CPU's `mem_read`/`mem_write`/`mem_resp` interface and stands in for physical memory in the system top level and in simulation.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to `mem_resp`; legal range 1..255.
- `ADDR_W`, default 10: word-index width; the store holds 2^ADDR_W words.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `mem_read` input, 1 bit: read request; held by the CPU until `mem_resp`.
- `mem_write` input, 1 bit: write request; held by the CPU until `mem_resp`.
- `mem_address` input, 16 bits (`lc3b_word`): byte address; bit 0 is ignored.
- `mem_wdata` input, 16 bits (`lc3b_word`): write data.
- `mem_byte_enable` input, 2 bits (`lc3b_mem_wmask`): bit 0 enables the low byte, bit 1 enables the high byte.
- `mem_rdata` output, 16 bits (`lc3b_word`): read data; valid while `mem_resp` is high.
- `mem_resp` output, 1 bit: one-cycle completion pulse.
- `mem_err` output, 1 bit: sticky flag; set when a request arrives with both read and write asserted.
- `rd_count` output, 16 bits: number of completed reads (see Configuration).
- `wr_count` output, 16 bits: number of completed writes (see Configuration).

## Operation
- The word index is `mem_address[ADDR_W:1]`. Upper address bits are dropped, so addresses wrap modulo 2^(ADDR_W+1) bytes.
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE:** if `mem_read` or `mem_write` is high, latch the op, address, wdata and byte enable.
  - If `LATENCY`=1, go to RESP.
  - Otherwise, load the counter with `LATENCY`-2 and go to WAIT.
- **WAIT:** if both `mem_read` and `mem_write` are low, abort to IDLE; no write is performed.
  - If the counter is 0, go to RESP.
  - Otherwise, decrement the counter.
- **Entering RESP** (on that same edge):
  - A write updates only the bytes whose enable bit is set.
  - A read loads `mem_rdata` from the store.
- **RESP:** `mem_resp` is 1 for exactly one cycle, then the FSM returns to IDLE unconditionally. A request still asserted during RESP is ignored; the CPU's next request is sampled in IDLE.
- Input changes during WAIT are ignored; the latched values are used.
- Read and write asserted together: write takes priority and `mem_err` is set until reset.
- A write with `mem_byte_enable`=00 completes normally and `mem_resp` still pulses, but the store is unchanged.

## Timing
- A request first seen in IDLE in cycle 0 produces `mem_resp` in cycle `LATENCY`.
- Back-to-back throughput is one transaction per `LATENCY`+1 cycles.
- Read-after-write: a read issued after a write's RESP returns the new data.
- `mem_rdata` holds its value after RESP until the next read completes.
- Reset values:
  - FSM in IDLE, counter 0.
  - `mem_resp`=0, `mem_rdata`=0, `mem_err`=0, `rd_count`=0, `wr_count`=0.
- Reset mid-transaction abandons the transaction, and a pending write is not performed.
- Store contents are not affected by reset.

## Configuration
- `LC3B_MEM_STATS_EN` defined: `rd_count` and `wr_count` increment on each completed read or write in its RESP cycle, and saturate at 0xFFFF. Aborted requests are not counted.
- Macro undefined: both counters are tied to 0 and no counter registers exist. All ports are present in both cases.

## Structure
- Add to `lc3b_types`:
  - `lc3b_mem_state` enum (IDLE, WAIT, RESP).
  - `lc3b_mem_op` enum (mem_op_read, mem_op_write).
- Reuse the existing `lc3b_word` and `lc3b_mem_wmask` types.
- Single sub-module `lc3b_mem_array`: 2^ADDR_W × 16 storage with one synchronous port, a per-byte write enable, and a registered read. No reset.

## Test plan
- `LATENCY`=4: write 0xBEEF to 0x0040 with enable 11, then read 0x0040 → `mem_resp` 4 cycles after each request; `mem_rdata`=0xBEEF.
- Write 0x1234 to 0x0010, then write 0xAB00 to 0x0010 with enable 10; read 0x0011 → 0xAB34 (bit 0 ignored).
- With `ADDR_W`=10: write 0x5555 to 0x0802; read 0x0002 → 0x5555 (address wrap).
- Start a write to 0x0020 and drop `mem_write` in WAIT cycle 2 → no `mem_resp`; a later read of 0x0020 returns the prior value; `wr_count` unchanged.
- Assert `mem_read` and `mem_write` together → write performed, `mem_err`=1 until `rst`; assert `rst` mid-WAIT → all outputs 0 next cycle.
- `LATENCY`=1, three back-to-back reads → `mem_resp` in cycles 1, 3, 5; with `LC3B_MEM_STATS_EN` defined, `rd_count`=3.
